idu: RTL

Instruction decode unit for the NPC core: the producer side of the execute unit's operand interface. Accepts fetched 32-bit instructions over a valid/ready handshake and reads `rs1` from an internal 32×32 general-purpose register file. It emits the registered `ex_op`/`ex_src1`/`ex_imm`/`ex_funct3` bundle plus destination info, and absorbs the execute result back through a write-back port. A per-register busy scoreboard stalls issue on read-after-write hazards, and an `ebreak` or illegal instruction halts the front end.

---
 rtl/idu.sv | 139 +++++++++++++
 1 files changed

// File: rtl/idu.sv
`default_nettype none
// ============================================================================
// Module   : idu
// Brief    : Instruction decode unit. Decodes ADDI/EBREAK, reads rs1 from the
//            register file and tracks RAW hazards with a busy scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module idu #(
    parameter int XLEN    = 32,
    parameter int REG_NUM = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [6:0]      ex_op,
    output logic [XLEN-1:0] ex_src1,
    output logic [11:0]     ex_imm,
    output logic [2:0]      ex_funct3,
    output logic [4:0]      ex_rd,
    output logic            ex_wen,
    output logic            halt,
    output logic            ill_inst
);

    localparam logic [6:0]  c_OP_IMM = 7'b0010011;
    localparam logic [31:0] c_EBREAK = 32'h0010_0073;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t            r_state;
    logic [XLEN-1:0]   r_rf [REG_NUM];
    logic [REG_NUM-1:0] r_busy;
    logic              r_out_valid;
    logic [6:0]        r_op;
    logic [XLEN-1:0]   r_src1;
    logic [11:0]       r_imm;
    logic [2:0]        r_funct3;
    logic [4:0]        r_rd;
    logic              r_wen;
    logic              r_halt;
    logic              r_ill;

    logic [4:0]        w_rs1;
    logic [4:0]        w_rd;
    logic              w_is_addi;
    logic              w_is_ebreak;
    logic              w_bypass;
    logic              w_stall;
    logic              w_in_ready;
    logic              w_accept;
    logic [XLEN-1:0]   w_src1;

    assign w_rs1       = in_inst[19:15];
    assign w_rd        = in_inst[11:7];
    assign w_is_addi   = (in_inst[6:0] == c_OP_IMM) && (in_inst[14:12] == 3'b000);
    assign w_is_ebreak = (in_inst == c_EBREAK);
    assign w_bypass    = wb_en && (wb_rd == w_rs1);

    // A write-back landing this cycle resolves the hazard via the bypass.
    assign w_stall    = r_busy[w_rs1] && (w_rs1 != 5'd0) && !w_bypass;
    assign w_in_ready = (r_state == ST_RUN) && (!r_out_valid || out_ready) && !w_stall;
    assign w_accept   = in_valid && w_in_ready;

    always_comb begin
        w_src1 = r_rf[w_rs1];
        if (w_rs1 == 5'd0)
            w_src1 = '0;
        else if (w_bypass)
            w_src1 = wb_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_busy      <= '0;
            r_out_valid <= 1'b0;
            r_op        <= '0;
            r_src1      <= '0;
            r_imm       <= '0;
            r_funct3    <= '0;
            r_rd        <= '0;
            r_wen       <= 1'b0;
            r_halt      <= 1'b0;
            r_ill       <= 1'b0;
            for (int i = 0; i < REG_NUM; i++)
                r_rf[i] <= '0;
        end else begin
            if (wb_en && (wb_rd != 5'd0)) begin
                r_rf[wb_rd]   <= wb_data;
                r_busy[wb_rd] <= 1'b0;
            end

            if (w_accept && w_is_addi) begin
                r_out_valid <= 1'b1;
                r_op        <= in_inst[6:0];
                r_src1      <= w_src1;
                r_imm       <= in_inst[31:20];
                r_funct3    <= in_inst[14:12];
                r_rd        <= w_rd;
                r_wen       <= (w_rd != 5'd0);
                // Placed after the write-back clear so the newer producer wins.
                if (w_rd != 5'd0)
                    r_busy[w_rd] <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end

            if (w_accept && !w_is_addi) begin
                r_state <= ST_HALT;
                r_halt  <= 1'b1;
                if (!w_is_ebreak)
                    r_ill <= 1'b1;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign ex_op     = r_op;
    assign ex_src1   = r_src1;
    assign ex_imm    = r_imm;
    assign ex_funct3 = r_funct3;
    assign ex_rd     = r_rd;
    assign ex_wen    = r_wen;
    assign halt      = r_halt;
    assign ill_inst  = r_ill;

endmodule
`default_nettype wire
